cla_serial_resolver: RTL and testbench



---
 rtl/cla_serial_resolver_if.sv | 21 ++
 rtl/cla_serial_resolver.sv | 68 ++++++
 tb/tb_cla_serial_resolver.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cla_serial_resolver_if.sv
// cla_serial_resolver_if: operand/result handshake bundle for the serial carry resolver
// master drives in_valid/p/g/c_in/out_ready; slave drives in_ready/out_valid/sum/c_out
interface cla_serial_resolver_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  modport master (
    output in_valid, p, g, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out
  );
  modport slave (
    input  in_valid, p, g, c_in, out_ready,
    output in_ready, out_valid, sum, c_out
  );
endinterface

// File: rtl/cla_serial_resolver.sv
// cla_serial_resolver: resolves carries and sum from p/g words two bits per clock
// clk, rst_n (async active-low); bus.slave: in_valid/in_ready/p/g/c_in in, out_valid/out_ready/sum/c_out out
module cla_serial_resolver #(parameter int WIDTH = 8) (
  input logic                 clk,
  input logic                 rst_n,
  cla_serial_resolver_if.slave bus
);
  localparam int DW = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;
  localparam logic [DW-1:0] LAST = DW'(WIDTH / 2 - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] p_r, g_r, sum_r;
  logic [DW-1:0]    d;
  logic             c, c_out_r, in_ready_r, out_valid_r;
  logic [DW:0]      i;
  logic [1:0]       pd, gd;
  logic             c1, c2;
  assign i  = {d, 1'b0};
  assign pd = p_r[i +: 2];
  assign gd = g_r[i +: 2];
  assign c1 = gd[0] | (pd[0] & c);
  // c2 is a two-level lookahead from c, not a ripple through c1
  assign c2 = gd[1] | (pd[1] & gd[0]) | (pd[1] & pd[0] & c);
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.c_out     = c_out_r;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      c_out_r     <= 1'b0;
      d           <= '0;
      c           <= 1'b0;
      p_r         <= '0;
      g_r         <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          p_r        <= bus.p;
          g_r        <= bus.g;
          c          <= bus.c_in;
          d          <= '0;
          in_ready_r <= 1'b0;
          state      <= RUN;
        end
        RUN: begin
          sum_r[i +: 2] <= {pd[1] ^ c1, pd[0] ^ c};
          c             <= c2;
          d             <= d + 1'b1;
          if (d == LAST) begin
            c_out_r     <= c2;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_serial_resolver.sv
// tb_cla_serial_resolver: scoreboard bench comparing results against plain a+b+c_in arithmetic
module tb_cla_serial_resolver;
  localparam int WIDTH = 8;
  logic clk = 0, rst_n = 0;
  int compared = 0, failed = 0, cyc = 0, hs_cyc = -10, acc_cyc = 0;
  bit rnd = 0, held = 0;
  logic [WIDTH:0] held_v, e;
  logic [WIDTH:0] sb[$];
  cla_serial_resolver_if #(.WIDTH(WIDTH)) bus();
  cla_serial_resolver #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // p/g without overlap correspond to a=p|g, b=g, so the result is just a+b+c_in
  function automatic logic [WIDTH:0] model(logic [WIDTH-1:0] pp, gg, logic cc);
    return {1'b0, pp | gg} + {1'b0, gg} + {{WIDTH{1'b0}}, cc};
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send(input logic [WIDTH-1:0] pp, gg, input logic cc, input bit hold);
    int n = 0;
    bus.in_valid = 1; bus.p = pp; bus.g = gg; bus.c_in = cc;
    while (!bus.in_ready && n < 200) begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 0, 1);
      bus.in_valid = 0;
      return;
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    sb.push_back(model(pp, gg, cc));
    if (!hold) bus.in_valid = 0;
    bus.p = WIDTH'($urandom); bus.g = WIDTH'($urandom); bus.c_in = 1'($urandom);
  endtask
  task automatic send_ab(input logic [WIDTH-1:0] a, b, input logic cc);
    send(a ^ b, a & b, cc, 0);
  endtask
  task automatic drain();
    int n = 0;
    bus.out_ready = 1;
    while (sb.size() > 0 && n < 200) begin @(posedge clk); #1; n++; end
    if (sb.size() > 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (held) check("hold_stable", 32'({bus.c_out, bus.sum}), 32'(held_v));
      if (bus.out_ready) begin
        if (sb.size() == 0) check("unexpected_output", 32'({bus.c_out, bus.sum}), 32'h1ff);
        else begin
          e = sb.pop_front();
          check("result", 32'({bus.c_out, bus.sum}), 32'(e));
        end
        hs_cyc = cyc + 1;
        held = 0;
      end else begin
        held = 1;
        held_v = {bus.c_out, bus.sum};
      end
    end else held = 0;
  end
  initial begin
    int n;
    bus.in_valid = 0; bus.p = '0; bus.g = '0; bus.c_in = 0; bus.out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_sum", 32'({bus.c_out, bus.sum}), 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    bus.out_ready = 0;
    send(8'h00, 8'h00, 0, 0);
    check("run0_in_ready", 32'(bus.in_ready), 0);
    check("run0_out_valid", 32'(bus.out_valid), 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("run_in_ready", 32'(bus.in_ready), 0);
      check("run_out_valid", 32'(bus.out_valid), 0);
    end
    @(posedge clk); #1;
    check("latency_out_valid", 32'(bus.out_valid), 1);
    drain();
    send(8'hFE, 8'h01, 0, 0);
    send(8'hFF, 8'h00, 1, 0);
    send(8'hFF, 8'h00, 0, 0);
    drain();
    bus.out_ready = 0;
    send(8'h66, 8'h18, 0, 1);
    n = 0;
    while (!bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("bp_out_valid", 32'(bus.out_valid), 1);
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_in_ready", 32'(bus.in_ready), 0);
      check("bp_sum", 32'({bus.c_out, bus.sum}), 32'(model(8'h66, 8'h18, 0)));
    end
    bus.out_ready = 1; bus.in_valid = 0;
    @(posedge clk); #1;
    check("bp_release_out_valid", 32'(bus.out_valid), 0);
    check("bp_release_in_ready", 32'(bus.in_ready), 1);
    send(8'h0F, 8'h30, 1, 0);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 0);
    check("mid_rst_sum", 32'({bus.c_out, bus.sum}), 0);
    sb.delete();
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    send_ab(8'hA7, 8'h6D, 1);
    drain();
    send(8'h0F, 8'h00, 1, 1);
    send(8'h00, 8'h80, 0, 0);
    check("b2b_gap", 32'(acc_cyc), 32'(hs_cyc + 1));
    drain();
    rnd = 1;
    repeat (30) send_ab(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    rnd = 0;
    drain();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
